// File: rtl/mips_pkg.sv
// Shared Mini-MIPS datapath constants: widths, the zero register and the ALU op-codes
// that this stage passes straight through to the ALU.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_NOR = 3'b101;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b110;
  localparam logic [OP_W-1:0] ALU_SLL = 3'b111;

endpackage

// File: rtl/operand_stage_reg_file.sv
// General-purpose register file: two combinational read ports, one clocked write port,
// r0 hardwired to zero, whole array cleared by the asynchronous reset.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1_i,
  output logic [DATA_W-1:0] rd1_o,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // r0 is forced here as well so the read path never depends on regs_q[0]
  assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/operand_stage.sv
// ID/EX boundary: resolves ALU operands from the register file with EX and WB forwarding,
// extends the immediate, and holds the result in a single-entry valid/ready pipeline register.
module operand_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int OP_W   = mips_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] dst,
  input  logic [15:0]       imm,
  input  logic              use_imm,
  input  logic              sign_ext,
  input  logic [OP_W-1:0]   op,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              ex_fwd_en,
  input  logic [ADDR_W-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [ADDR_W-1:0] dst_q
);

  import mips_pkg::*;

  logic [DATA_W-1:0] rf_rs, rf_rt;
  logic [DATA_W-1:0] res_a, res_rt, res_b, imm_ext;
  logic              accept;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] dst_q_q, dst_q_d;

  reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1_i (rs),
    .rd1_o (rf_rs),
    .ra2_i (rt),
    .rd2_o (rf_rt),
    .we_i  (wb_en),
    .wa_i  (wb_addr),
    .wd_i  (wb_data)
  );

  // Priority: zero register, then the younger EX result, then same-cycle writeback.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_en,
    input logic [ADDR_W-1:0] ex_addr,
    input logic [DATA_W-1:0] ex_data,
    input logic              w_en,
    input logic [ADDR_W-1:0] w_addr,
    input logic [DATA_W-1:0] w_data
  );
    logic [DATA_W-1:0] r;
    if (src == REG_ZERO)                  r = '0;
    else if (ex_en && (ex_addr == src))   r = ex_data;
    else if (w_en && (w_addr == src))     r = w_data;
    else                                  r = rf_val;
    return r;
  endfunction

  always_comb begin
    res_a   = resolve(rs, rf_rs, ex_fwd_en, ex_fwd_addr, ex_fwd_data, wb_en, wb_addr, wb_data);
    res_rt  = resolve(rt, rf_rt, ex_fwd_en, ex_fwd_addr, ex_fwd_data, wb_en, wb_addr, wb_data);
    imm_ext = {{(DATA_W-16){imm[15] & sign_ext}}, imm};
    res_b   = use_imm ? imm_ext : res_rt;
  end

  assign in_ready = !valid_q || ex_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dst_q_d = dst_q_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      a_d     = res_a;
      b_d     = res_b;
      op_d    = op;
      dst_q_d = dst;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dst_q_q <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dst_q_q <= dst_q_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign dst_q     = dst_q_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the register file and pipeline register.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs, rt, dst;
  logic [15:0] imm;
  logic        use_imm, sign_ext;
  logic [2:0]  op;
  logic        flush, ex_ready;
  logic        ex_fwd_en;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  dst_q;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_dst;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs          (rs),
    .rt          (rt),
    .dst         (dst),
    .imm         (imm),
    .use_imm     (use_imm),
    .sign_ext    (sign_ext),
    .op          (op),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .ex_fwd_en   (ex_fwd_en),
    .ex_fwd_addr (ex_fwd_addr),
    .ex_fwd_data (ex_fwd_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .dst_q       (dst_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_dst = '0;
  endtask

  function automatic logic [31:0] m_resolve(input logic [4:0] s);
    if (s == 0) return 32'd0;
    if (ex_fwd_en && ex_fwd_addr == s) return ex_fwd_data;
    if (wb_en && wb_addr == s) return wb_data;
    return m_rf[s];
  endfunction

  task automatic idle();
    in_valid = 0; rs = 0; rt = 0; dst = 0; imm = 0; use_imm = 0; sign_ext = 0; op = 0;
    flush = 0; ex_ready = 1; ex_fwd_en = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  // Called just after a falling edge with inputs already driven; advances one cycle.
  task automatic step();
    logic        acc;
    logic [31:0] ea, eb;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || ex_ready)});
    acc = in_valid && (!m_valid || ex_ready);
    ea  = m_resolve(rs);
    if (use_imm) eb = sign_ext ? {{16{imm[15]}}, imm} : {16'd0, imm};
    else         eb = m_resolve(rt);
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_a = ea; m_b = eb; m_op = op; m_dst = dst;
    end else if (ex_ready) m_valid = 1'b0;
    if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", {29'd0, alu_op}, {29'd0, m_op});
      chk("dst_q", {27'd0, dst_q}, {27'd0, m_dst});
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held_a, held_b;
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_dst_q", {27'd0, dst_q}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // write then read
    wb_en = 1; wb_addr = 1; wb_data = 25; step();
    wb_addr = 2; wb_data = 15; step();
    idle(); in_valid = 1; rs = 1; rt = 2; op = 3'b000; dst = 5'd9; step();
    chk("wr_rd_valid", {31'd0, out_valid}, 32'd1);
    chk("wr_rd_a", alu_a, 32'd25);
    chk("wr_rd_b", alu_b, 32'd15);

    // immediate extension
    idle(); in_valid = 1; rs = 1; imm = 16'hFFF1; use_imm = 1; sign_ext = 1; step();
    chk("imm_sext", alu_b, 32'hFFFF_FFF1);
    sign_ext = 0; step();
    chk("imm_zext", alu_b, 32'h0000_FFF1);

    // forwarding priority
    idle(); in_valid = 1; rs = 3; wb_en = 1; wb_addr = 3; wb_data = 30; step();
    chk("fwd_wb", alu_a, 32'd30);
    idle(); in_valid = 1; rs = 3; wb_en = 1; wb_addr = 3; wb_data = 7;
    ex_fwd_en = 1; ex_fwd_addr = 3; ex_fwd_data = 45; step();
    chk("fwd_ex_over_wb", alu_a, 32'd45);
    idle(); in_valid = 1; rs = 0; ex_fwd_en = 1; ex_fwd_addr = 0; ex_fwd_data = 99; step();
    chk("fwd_r0", alu_a, 32'd0);

    // r0 protection
    idle(); wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD_BEEF; step();
    idle(); in_valid = 1; rt = 0; use_imm = 0; step();
    chk("r0_read", alu_b, 32'd0);

    // stall then flush
    idle(); in_valid = 1; rs = 1; rt = 2; step();
    held_a = alu_a; held_b = alu_b;
    chk("stall_cap_a", held_a, 32'd25);
    chk("stall_cap_b", held_b, 32'd15);
    idle(); in_valid = 1; rs = 3; rt = 3; ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_a", alu_a, 32'd25);
      chk("stall_b", alu_b, 32'd15);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    flush = 1; step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    idle(); step();
    chk("flush_no_beat", {31'd0, out_valid}, 32'd0);

    // randomized traffic with narrow addresses to provoke hazards
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      rs          = 5'($urandom_range(0, 7));
      rt          = 5'($urandom_range(0, 7));
      dst         = 5'($urandom);
      imm         = 16'($urandom);
      use_imm     = $urandom_range(0, 1) == 1;
      sign_ext    = $urandom_range(0, 1) == 1;
      op          = 3'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      ex_ready    = ($urandom_range(0, 9) < 7);
      ex_fwd_en   = $urandom_range(0, 1) == 1;
      ex_fwd_addr = 5'($urandom_range(0, 7));
      ex_fwd_data = $urandom;
      wb_en       = $urandom_range(0, 1) == 1;
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      step();
    end

    // reset in the middle of a stall
    idle(); in_valid = 1; rs = 1; rt = 2; step();
    idle(); in_valid = 1; rs = 1; rt = 2; wb_en = 1; wb_addr = 1; wb_data = 32'h1234; step();
    idle(); wb_en = 1; wb_addr = 2; wb_data = 32'h5678; ex_ready = 0; step();
    idle(); ex_ready = 0; step();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_a", alu_a, 32'd0);
    chk("async_rst_b", alu_b, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle(); in_valid = 1; rs = 1; rt = 2; step();
    chk("post_rst_r1", alu_a, 32'd0);
    chk("post_rst_r2", alu_b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
